// File: rtl/packet_receiver.sv
// packet_receiver: HDMI sink-side data-island packet reassembler.
// Collects TERC4-decoded nibbles over 32 pixel clocks and rebuilds a 24-bit
// header plus four 56-bit subpackets. Each packet is presented with a single
// cycle packet_valid strobe. Broken framing is reported on framing_error.
// Build option: define PACKET_RX_ECC_EN to include the BCH ECC checkers.
// Without it the ECC bytes are received and ignored, and the ok flags read as
// all-good for every presented packet.
module packet_receiver (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        data_island,
    input  logic [3:0]  terc4_ch0,
    input  logic [3:0]  terc4_ch1,
    input  logic [3:0]  terc4_ch2,
    output logic        packet_valid,
    output logic [23:0] header,
    output logic [55:0] sub0,
    output logic [55:0] sub1,
    output logic [55:0] sub2,
    output logic [55:0] sub3,
    output logic        header_ecc_ok,
    output logic [3:0]  sub_ecc_ok,
    output logic        framing_error,
    output logic        hsync,
    output logic        vsync
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;

    // cnt_q is the packet cycle index expected on the current clock
    logic [4:0]  cnt_q;
    logic [4:0]  cnt_d;

    // Remembers that this island already produced its idle framing error
    logic        island_err_q;
    logic        island_err_d;

    // Capture controls derived by the FSM for the current cycle
    logic        rx_en;
    logic [4:0]  rx_idx;
    logic        rx_last;
    logic        ferr_d;

    // Packet assembly storage, written bit by bit at the packet cycle index
    logic [23:0] hdr_sr;
    logic [55:0] sub_sr [4];

    // Next-state logic: decides whether this cycle captures a packet bit,
    // restarts a packet, or aborts with a framing error.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        island_err_d = island_err_q;
        rx_en        = 1'b0;
        rx_idx       = 5'd0;
        ferr_d       = 1'b0;
        rx_last      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 5'd0;
                if (!data_island) begin
                    island_err_d = 1'b0;
                end else if (!terc4_ch0[3]) begin
                    state_d = RECV;
                    rx_en   = 1'b1;
                    rx_idx  = 5'd0;
                    cnt_d   = 5'd1;
                end else if (!island_err_q) begin
                    ferr_d       = 1'b1;
                    island_err_d = 1'b1;
                end
            end
            RECV: begin
                if (!data_island) begin
                    state_d      = IDLE;
                    cnt_d        = 5'd0;
                    island_err_d = 1'b0;
                    ferr_d       = (cnt_q != 5'd0);
                end else if (!terc4_ch0[3] && (cnt_q != 5'd0)) begin
                    ferr_d = 1'b1;
                    rx_en  = 1'b1;
                    rx_idx = 5'd0;
                    cnt_d  = 5'd1;
                end else if (terc4_ch0[3] && (cnt_q == 5'd0)) begin
                    ferr_d       = 1'b1;
                    island_err_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    rx_en  = 1'b1;
                    rx_idx = cnt_q;
                    cnt_d  = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase

        rx_last = rx_en && (rx_idx == 5'd31);
    end

    // State register for the receive FSM and its cycle counter
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 5'd0;
            island_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            island_err_q <= island_err_d;
        end
    end

    // Packet assembly, output latching, strobes and sync passthrough
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            packet_valid  <= 1'b0;
            framing_error <= 1'b0;
            header        <= 24'd0;
            sub0          <= 56'd0;
            sub1          <= 56'd0;
            sub2          <= 56'd0;
            sub3          <= 56'd0;
            hsync         <= 1'b0;
            vsync         <= 1'b0;
            hdr_sr        <= 24'd0;
            for (int k = 0; k < 4; k++) begin
                sub_sr[k] <= 56'd0;
            end
        end else begin
            packet_valid  <= rx_last;
            framing_error <= ferr_d;

            if (data_island) begin
                hsync <= terc4_ch0[0];
                vsync <= terc4_ch0[1];
            end

            if (rx_en) begin
                if (rx_idx < 5'd24) begin
                    hdr_sr[rx_idx] <= terc4_ch0[2];
                end
                if (rx_idx < 5'd28) begin
                    for (int k = 0; k < 4; k++) begin
                        sub_sr[k][{rx_idx, 1'b0}] <= terc4_ch1[k];
                        sub_sr[k][{rx_idx, 1'b1}] <= terc4_ch2[k];
                    end
                end
            end

            if (rx_last) begin
                header <= hdr_sr;
                sub0   <= sub_sr[0];
                sub1   <= sub_sr[1];
                sub2   <= sub_sr[2];
                sub3   <= sub_sr[3];
            end
        end
    end

`ifdef PACKET_RX_ECC_EN

    // One BCH step: shift one data bit into the 8-bit remainder
    function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
        bch_step = {1'b0, e[7:1]} ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
    endfunction

    logic [7:0] hdr_ecc_q;
    logic [7:0] sub_ecc_q [4];
    logic [6:0] hdr_ecc_rx;
    logic [5:0] sub_ecc_rx [4];

    // BCH remainders over the data bits, received ECC capture and comparison
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hdr_ecc_q     <= 8'd0;
            hdr_ecc_rx    <= 7'd0;
            header_ecc_ok <= 1'b0;
            sub_ecc_ok    <= 4'd0;
            for (int k = 0; k < 4; k++) begin
                sub_ecc_q[k]  <= 8'd0;
                sub_ecc_rx[k] <= 6'd0;
            end
        end else if (rx_en) begin
            if (rx_idx < 5'd24) begin
                hdr_ecc_q <= bch_step((rx_idx == 5'd0) ? 8'h00 : hdr_ecc_q, terc4_ch0[2]);
            end else if (!rx_last) begin
                hdr_ecc_rx[rx_idx[2:0]] <= terc4_ch0[2];
            end

            for (int k = 0; k < 4; k++) begin
                if (rx_idx < 5'd28) begin
                    sub_ecc_q[k] <= bch_step(bch_step((rx_idx == 5'd0) ? 8'h00 : sub_ecc_q[k],
                                                      terc4_ch1[k]),
                                             terc4_ch2[k]);
                end else if (!rx_last) begin
                    sub_ecc_rx[k][{rx_idx[1:0], 1'b0}] <= terc4_ch1[k];
                    sub_ecc_rx[k][{rx_idx[1:0], 1'b1}] <= terc4_ch2[k];
                end
            end

            if (rx_last) begin
                header_ecc_ok <= (hdr_ecc_q == {terc4_ch0[2], hdr_ecc_rx});
                for (int k = 0; k < 4; k++) begin
                    sub_ecc_ok[k] <= (sub_ecc_q[k] == {terc4_ch2[k], terc4_ch1[k], sub_ecc_rx[k]});
                end
            end
        end
    end

`else

    // Without checkers every presented packet is flagged as ECC-good
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            header_ecc_ok <= 1'b0;
            sub_ecc_ok    <= 4'd0;
        end else if (rx_last) begin
            header_ecc_ok <= 1'b1;
            sub_ecc_ok    <= 4'hF;
        end
    end

`endif

endmodule
